fp_mem_sat_reduce: RTL and testbench
====================================

Name: fp_mem_sat_reduce

Overview:
- Calyx-style go/done component that consumes a std_mem_d1 port of signed fixed-point words.
- Walks addresses 0..SIZE-1 and accumulates a per-step saturating signed sum. Presents the result on `out` and pulses `done`.
- Sits downstream of the identity/copy stage that fills mem0. Drives the same mem port bundle, read-only.

Parameters:
- WIDTH, 4: word width, two's-complement signed fixed point. The binary point is irrelevant to addition, so no fraction parameter.
- SIZE, 4: number of memory words reduced, ≥1.
- IDX_SIZE, 2: address width, ≥ clog2(SIZE), ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- go  in  1  start request, Calyx convention.
- done  out  1  one-cycle completion pulse.
- out  out  WIDTH  saturated sum, held between runs.
- mem0_addr0  out  IDX_SIZE  read address.
- mem0_write_data  out  WIDTH  tied 0.
- mem0_write_en  out  1  tied 0.
- mem0_clk  out  1  equals clk.
- mem0_read_data  in  WIDTH  combinational read data for mem0_addr0.
- mem0_done  in  1  ignored; the block never writes.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. Reset forces state=IDLE, acc=0, idx=0, out=0, done=0, regardless of go.
- Reset mid-run abandons the run: no done pulse, out=0.
- Memory port: read is combinational, so mem0_read_data is valid in the same cycle as mem0_addr0. mem0_addr0=idx in RUN and 0 otherwise.

FSM states (registered):
- IDLE: done=0. If go=1: acc<=0, idx<=0, goto RUN. Otherwise stay.
- RUN: acc<=sat(acc+mem0_read_data), with mem0_addr0=idx.
  - If idx==SIZE-1: out<=sat(acc+mem0_read_data), goto DONE.
  - Otherwise idx<=idx+1.
- DONE: done=1 for exactly this cycle, goto IDLE unconditionally.

Timing:
- Latency: go sampled high at cycle 0 → RUN occupies cycles 1..SIZE → done=1 in cycle SIZE+1.
- out is valid from the DONE cycle and holds until the next DONE or reset.
- go is ignored in RUN and DONE. Deasserting go mid-run does not abort.

Handshake:
- The parent drops go in the cycle it observes done.
- If go is still high in IDLE, a new run starts; back-to-back runs are legal.

Arithmetic:
- Sign-extend both operands to WIDTH+1 and add.
- Result > 2^(WIDTH-1)-1 → clamp to max. Result < -2^(WIDTH-1) → clamp to min. Otherwise truncate to WIDTH.
- Saturation is applied every step, not only at the end, so order matters.

Boundaries:
- SIZE=1: a single RUN cycle; out=mem[0].
- idx never exceeds SIZE-1 and never wraps.

Test Plan:
- WIDTH=4, SIZE=4, mem=[1,2,-1,3], go pulse at cycle 0 → addr sequence 0,1,2,3 in cycles 1–4; done=1 only in cycle 5; out=5; write_en=0 throughout.
- mem=[7,7,-8,0] → per-step saturation 7→7→-1→-1, out=-1 (0xF). mem=[-8,-8,-8,-8] → out=-8 (0x8).
- SIZE=1 build, mem=[-3] → done in cycle 2, out=-3 (0xD).
- Run mem=[1,1,1,1] to done (out=4), then assert reset in cycle 2 of a second run → out=0, done never pulses, state IDLE; a fresh go then yields out=4.
- go held high continuously → done pulses every SIZE+2 cycles, out stable between pulses. go dropped in cycle 2 of a run → run still completes with the correct out.
- Random mem contents over 200 runs against a saturating reference model → out and done timing match exactly.

Source files
------------

// File: rtl/fp_mem_sat_reduce.sv
// Go/done reducer: walks a read-only std_mem_d1 port and accumulates a per-step
// saturating signed sum of its words, presenting the result on out with a done pulse.
module fp_mem_sat_reduce #(
    parameter int WIDTH    = 4,
    parameter int SIZE     = 4,
    parameter int IDX_SIZE = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    output logic                       done,
    output logic signed [WIDTH-1:0]    out,
    output logic [IDX_SIZE-1:0]        mem0_addr0,
    output logic [WIDTH-1:0]           mem0_write_data,
    output logic                       mem0_write_en,
    output logic                       mem0_clk,
    input  logic signed [WIDTH-1:0]    mem0_read_data,
    input  logic                       mem0_done
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [IDX_SIZE-1:0] LAST = IDX_SIZE'(SIZE - 1);

    state_t                  state;
    logic signed [WIDTH-1:0] acc;
    logic [IDX_SIZE-1:0]     idx;
    logic signed [WIDTH-1:0] sum;
    logic                    unused_mem_done;

    // Add in WIDTH+1 bits; a disagreement between the top two bits means overflow,
    // and the top bit tells which rail to clamp to.
    function automatic logic signed [WIDTH-1:0] sat_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1])
            sat_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            sat_add = s[WIDTH-1:0];
    endfunction

    assign sum             = sat_add(acc, mem0_read_data);
    assign mem0_addr0      = (state == RUN) ? idx : '0;
    assign mem0_write_data = '0;
    assign mem0_write_en   = 1'b0;
    assign mem0_clk        = clk;
    assign unused_mem_done = mem0_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum;
                    if (idx == LAST) begin
                        out   <= sum;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mem_sat_reduce.sv
// Bench for fp_mem_sat_reduce: a SIZE=4 and a SIZE=1 instance, each fed by a
// combinational memory array and checked against a plain-integer saturating sum.
module tb_fp_mem_sat_reduce;

    localparam int W  = 4;
    localparam int SZ = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                  go, done, write_en, mclk;
    logic signed [W-1:0]   out;
    logic [1:0]            addr;
    logic [W-1:0]          write_data;
    logic signed [W-1:0]   mem [SZ];
    logic signed [W-1:0]   rd;
    assign rd = mem[addr];

    logic                  go1, done1, write_en1, mclk1;
    logic signed [W-1:0]   out1;
    logic [0:0]            addr1;
    logic [W-1:0]          write_data1;
    logic signed [W-1:0]   mem1;

    fp_mem_sat_reduce #(.WIDTH(W), .SIZE(SZ), .IDX_SIZE(2)) dut (
        .clk(clk), .reset(reset), .go(go), .done(done), .out(out),
        .mem0_addr0(addr), .mem0_write_data(write_data), .mem0_write_en(write_en),
        .mem0_clk(mclk), .mem0_read_data(rd), .mem0_done(1'b0)
    );

    fp_mem_sat_reduce #(.WIDTH(W), .SIZE(1), .IDX_SIZE(1)) dut1 (
        .clk(clk), .reset(reset), .go(go1), .done(done1), .out(out1),
        .mem0_addr0(addr1), .mem0_write_data(write_data1), .mem0_write_en(write_en1),
        .mem0_clk(mclk1), .mem0_read_data(mem1), .mem0_done(1'b0)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: running sum with clamping to the signed 4-bit range after every add.
    function automatic int ref_sum();
        int acc = 0;
        for (int i = 0; i < SZ; i++) begin
            acc += int'(mem[i]);
            if (acc > 7) acc = 7;
            if (acc < -8) acc = -8;
        end
        return acc;
    endfunction

    task automatic set_mem(input int a, input int b, input int c, input int d);
        mem[0] = W'(a); mem[1] = W'(b); mem[2] = W'(c); mem[3] = W'(d);
    endtask

    // Starts in an IDLE cycle at a negedge, ends at the negedge of the following IDLE cycle.
    task automatic run_one(input bit hold, input bit drop2);
        int exp = ref_sum();
        go = 1'b1;
        for (int k = 1; k <= SZ + 1; k++) begin
            @(negedge clk);
            check_eq("addr", int'(addr), (k <= SZ) ? k - 1 : 0);
            check_eq("done", int'(done), (k == SZ + 1) ? 1 : 0);
            check_eq("wr_en", int'(write_en), 0);
            if (k == SZ + 1) begin
                check_eq("out", int'(out), exp);
                if (!hold) go = 1'b0;
            end
            if (drop2 && k == 2) go = 1'b0;
        end
        @(negedge clk);
        check_eq("done_after", int'(done), 0);
        check_eq("out_held", int'(out), exp);
    endtask

    task automatic run_one1(input int v);
        mem1 = W'(v);
        go1 = 1'b1;
        @(negedge clk);
        check_eq("s1_addr", int'(addr1), 0);
        check_eq("s1_done_run", int'(done1), 0);
        @(negedge clk);
        check_eq("s1_done", int'(done1), 1);
        check_eq("s1_out", int'(out1), v);
        go1 = 1'b0;
        @(negedge clk);
        check_eq("s1_done_after", int'(done1), 0);
    endtask

    initial begin
        reset = 1'b1; go = 1'b1; go1 = 1'b1;
        set_mem(0, 0, 0, 0); mem1 = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_out", int'(out), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_addr", int'(addr), 0);
        check_eq("rst_wdata", int'(write_data), 0);
        check_eq("rst_out1", int'(out1), 0);
        check_eq("rst_done1", int'(done1), 0);
        go = 1'b0; go1 = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        set_mem(1, 2, -1, 3);   run_one(0, 0);
        check_eq("dir_5", int'(out), 5);
        set_mem(7, 7, -8, 0);   run_one(0, 0);
        check_eq("dir_m1", int'(out), -1);
        set_mem(-8, -8, -8, -8); run_one(0, 0);
        check_eq("dir_m8", int'(out), -8);

        run_one1(-3);
        run_one1(7);
        run_one1(-8);

        // Reset in cycle 2 of a run abandons it
        set_mem(1, 1, 1, 1);    run_one(0, 0);
        check_eq("pre_rst_out", int'(out), 4);
        go = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; go = 1'b0;
        @(negedge clk);
        check_eq("midrst_out", int'(out), 0);
        check_eq("midrst_done", int'(done), 0);
        check_eq("midrst_addr", int'(addr), 0);
        reset = 1'b0;
        for (int i = 0; i < SZ + 2; i++) begin
            @(negedge clk);
            check_eq("midrst_nodone", int'(done), 0);
            check_eq("midrst_idle_addr", int'(addr), 0);
        end
        run_one(0, 0);
        check_eq("post_rst_out", int'(out), 4);

        // go held high: back-to-back runs every SZ+2 cycles
        set_mem(3, -2, 5, 1);
        for (int r = 0; r < 3; r++) run_one(1, 0);
        go = 1'b0;
        @(negedge clk);
        check_eq("b2b_stop", int'(done), 0);

        // go dropped in cycle 2 still completes
        set_mem(-5, -6, 2, 4);  run_one(0, 1);

        for (int r = 0; r < 200; r++) begin
            bit hold;
            for (int i = 0; i < SZ; i++) mem[i] = W'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0);
            run_one(hold, $urandom_range(0, 4) == 0);
            if (!hold) begin
                go = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check_eq("gap_done", int'(done), 0);
                end
            end
        end
        go = 1'b0;

        for (int r = 0; r < 10; r++) run_one1(int'($signed(W'($urandom_range(0, 15)))));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
